// File: rtl/assert_pkg.sv
// Simulation helper for protocol checkers: reports a violation and stops the run.
package assert_pkg;

  task automatic err(input string who, input string msg);
    $fatal(1, "[%s] %s", who, msg);
  endtask

endpackage

// File: rtl/vr_assert_monitor.sv
// Multi-channel valid/ready protocol monitor: detects dropped valid, payload change
// while stalled and stall timeout; keeps sticky flags, a saturating count and a first-error capture.
module vr_assert_monitor #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned FATAL   = 0,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        err_drop,
  output logic [NUM_CH-1:0]        err_change,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic                     err_any,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_vld,
  output logic [CH_W-1:0]          first_ch,
  output logic [1:0]               first_code
);

  localparam int unsigned SC_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned EV_W  = $clog2(3 * NUM_CH + 1);
  localparam int unsigned SUM_W = CNT_W + EV_W;

  logic [NUM_CH-1:0] pend, pend_d;
  logic [DATA_W-1:0] data_q      [NUM_CH];
  logic [DATA_W-1:0] data_d      [NUM_CH];
  logic [SC_W-1:0]   stall_cnt   [NUM_CH];
  logic [SC_W-1:0]   stall_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] stall_c, drop_c, change_c, tmo_c;
  logic [NUM_CH-1:0] drop_d, change_d, tmo_d;
  logic [EV_W-1:0]   ev_cnt;
  logic              any_ev, fv_base, cap_load_c;
  logic [CNT_W-1:0]  base_cnt, count_d;
  logic [SUM_W-1:0]  sum;
  logic              first_vld_d;
  logic [CH_W-1:0]   first_ch_d;
  logic [1:0]        first_code_d;

  // Per-channel tracking state and violation detection
  always_comb begin
    stall_c  = valid & ~ready;
    pend_d   = en ? stall_c : '0;
    drop_c   = '0;
    change_c = '0;
    tmo_c    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      data_d[i]      = stall_c[i] ? data[i*DATA_W +: DATA_W] : data_q[i];
      stall_cnt_d[i] = '0;
      if (en && stall_c[i]) begin
        // Saturates at TIMEOUT so a single stall episode fires only once
        stall_cnt_d[i] = (stall_cnt[i] != SC_W'(TIMEOUT)) ? stall_cnt[i] + SC_W'(1) : stall_cnt[i];
      end
      if (en && pend[i]) begin
        drop_c[i]   = ~valid[i];
        change_c[i] = valid[i] && (data[i*DATA_W +: DATA_W] != data_q[i]);
      end
      tmo_c[i] = en && (TIMEOUT != 0) && stall_c[i] && (stall_cnt[i] == SC_W'(TIMEOUT - 1));
    end
  end

  // Error bookkeeping; a clear in the same cycle as a violation keeps the new violation
  always_comb begin
    ev_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ev_cnt = ev_cnt + EV_W'(drop_c[i]) + EV_W'(change_c[i]) + EV_W'(tmo_c[i]);
    end
    any_ev   = |{drop_c, change_c, tmo_c};
    base_cnt = clear ? '0 : err_count;
    sum      = SUM_W'(base_cnt) + SUM_W'(ev_cnt);
    count_d  = (sum[SUM_W-1:CNT_W] != '0) ? '1 : CNT_W'(sum);

    drop_d   = (clear ? '0 : err_drop)    | drop_c;
    change_d = (clear ? '0 : err_change)  | change_c;
    tmo_d    = (clear ? '0 : err_timeout) | tmo_c;

    fv_base      = first_vld & ~clear;
    cap_load_c   = ~fv_base & any_ev;
    first_vld_d  = fv_base | any_ev;
    first_ch_d   = clear ? '0 : first_ch;
    first_code_d = clear ? 2'd0 : first_code;
    if (cap_load_c) begin
      // Scan downwards so the lowest violating channel is the last one written
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        if (drop_c[i] || change_c[i] || tmo_c[i]) begin
          first_ch_d   = CH_W'(i);
          first_code_d = drop_c[i] ? 2'd1 : (change_c[i] ? 2'd2 : 2'd3);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend        <= '0;
      err_drop    <= '0;
      err_change  <= '0;
      err_timeout <= '0;
      err_any     <= 1'b0;
      err_count   <= '0;
      first_vld   <= 1'b0;
      first_ch    <= '0;
      first_code  <= 2'd0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        data_q[i]    <= '0;
        stall_cnt[i] <= '0;
      end
    end else begin
      pend        <= pend_d;
      err_drop    <= drop_d;
      err_change  <= change_d;
      err_timeout <= tmo_d;
      err_any     <= |{drop_d, change_d, tmo_d};
      err_count   <= count_d;
      first_vld   <= first_vld_d;
      first_ch    <= first_ch_d;
      first_code  <= first_code_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        data_q[i]    <= data_d[i];
        stall_cnt[i] <= stall_cnt_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  if (FATAL != 0) begin : g_fatal
    always_ff @(posedge clk) begin
      if (rst_n && cap_load_c) begin
        assert_pkg::err("vr_assert_monitor",
                        $sformatf("first violation on channel %0d, code %0d", first_ch_d, first_code_d));
      end
    end
  end
`endif

endmodule

// File: tb/tb_vr_assert_monitor.sv
// Directed bench for vr_assert_monitor: expected output snapshots are queued per cycle
// and checked by an independent monitor one edge later.
module tb_vr_assert_monitor;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n, en, clear;
  logic [NUM_CH-1:0]        valid, ready;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        err_drop, err_change, err_timeout;
  logic                     err_any;
  logic [CNT_W-1:0]         err_count;
  logic                     first_vld;
  logic [0:0]               first_ch;
  logic [1:0]               first_code;

  vr_assert_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .FATAL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .valid(valid), .ready(ready), .data(data),
    .err_drop(err_drop), .err_change(err_change), .err_timeout(err_timeout),
    .err_any(err_any), .err_count(err_count),
    .first_vld(first_vld), .first_ch(first_ch), .first_code(first_code)
  );

  always #5 clk = ~clk;

  // Expected state, hand-maintained by the stimulus
  logic [1:0] e_drop, e_chg, e_tmo, e_cnt, e_fcode;
  logic       e_fv, e_fch;

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic zero_exp();
    e_drop = '0; e_chg = '0; e_tmo = '0; e_cnt = '0;
    e_fv = 1'b0; e_fch = 1'b0; e_fcode = 2'd0;
  endtask

  // Queue the outputs expected after the next rising edge, then advance one cycle
  task automatic step(input string name);
    exp_q.push_back({e_drop, e_chg, e_tmo, |{e_drop, e_chg, e_tmo}, e_cnt, e_fv, e_fch, e_fcode});
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: every registered output update is compared against the oldest expectation
  always @(posedge clk) begin
    logic [12:0] act, expv;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      nm   = name_q.pop_front();
      act  = {err_drop, err_change, err_timeout, err_any, err_count, first_vld, first_ch, first_code};
      n_vec++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL %s @%0t: got drop=%b chg=%b tmo=%b any=%b cnt=%0d fv=%b ch=%0d code=%0d, expected drop=%b chg=%b tmo=%b any=%b cnt=%0d fv=%b ch=%0d code=%0d",
                 nm, $time, act[12:11], act[10:9], act[8:7], act[6], act[5:4], act[3], act[2], act[1:0],
                 expv[12:11], expv[10:9], expv[8:7], expv[6], expv[5:4], expv[3], expv[2], expv[1:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clear = 1'b0;
    valid = '0; ready = '0; data = '0;
    zero_exp();
    step("reset0");
    step("reset1");
    rst_n = 1'b1;

    // Clean traffic: 3-cycle stall with stable payload, then handshake
    valid[0] = 1'b1; data[15:0] = 16'h1234;
    for (int k = 0; k < 3; k++) step("clean_stall");
    ready[0] = 1'b1;
    step("clean_hs");
    valid[0] = 1'b0; ready[0] = 1'b0;
    step("clean_idle");

    // Drop on channel 1
    valid[1] = 1'b1;
    step("drop_stall");
    valid[1] = 1'b0;
    e_drop = 2'b10; e_cnt = 2'd1; e_fv = 1'b1; e_fch = 1'b1; e_fcode = 2'd1;
    step("drop");
    step("drop_sticky");
    clear = 1'b1; zero_exp();
    step("clear");
    clear = 1'b0;

    // Change on ch0 plus drop on ch1 in one cycle: ch0 wins the capture
    valid = 2'b11; data[15:0] = 16'hAAAA; data[31:16] = 16'h5555;
    step("chg_stall");
    data[15:0] = 16'hAAAB; valid[1] = 1'b0;
    e_chg = 2'b01; e_drop = 2'b10; e_cnt = 2'd2; e_fv = 1'b1; e_fch = 1'b0; e_fcode = 2'd2;
    step("chg_drop");
    step("chg_new_ref");
    ready[0] = 1'b1;
    step("chg_hs");
    valid[0] = 1'b0; ready[0] = 1'b0;
    step("chg_idle");
    clear = 1'b1; zero_exp();
    step("clear");
    clear = 1'b0;

    // Timeout: fires once on the 4th stalled edge, again in a second episode
    valid[0] = 1'b1; data[15:0] = 16'h0F0F;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) begin
        e_tmo = 2'b01; e_cnt = 2'd1; e_fv = 1'b1; e_fch = 1'b0; e_fcode = 2'd3;
      end
      step("tmo_stall");
    end
    ready[0] = 1'b1;
    step("tmo_release");
    ready[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) e_cnt = 2'd2;
      step("tmo_stall2");
    end
    ready[0] = 1'b1;
    step("tmo_hs");
    valid[0] = 1'b0; ready[0] = 1'b0;
    step("tmo_idle");
    clear = 1'b1; zero_exp();
    step("clear");
    clear = 1'b0;

    // Saturation with a 2-bit counter, then clear with a concurrent drop on ch0
    for (int k = 1; k <= 5; k++) begin
      valid[1] = 1'b1;
      step("sat_stall");
      valid[1] = 1'b0;
      e_drop = 2'b10; e_cnt = (k >= 3) ? 2'd3 : 2'(k);
      e_fv = 1'b1; e_fch = 1'b1; e_fcode = 2'd1;
      step("sat_drop");
    end
    valid[0] = 1'b1;
    step("sat_ch0_stall");
    valid[0] = 1'b0; clear = 1'b1;
    e_drop = 2'b01; e_chg = '0; e_tmo = '0; e_cnt = 2'd1; e_fv = 1'b1; e_fch = 1'b0; e_fcode = 2'd1;
    step("clear_with_drop");
    clear = 1'b0;
    step("post_clear");
    clear = 1'b1; zero_exp();
    step("clear");
    clear = 1'b0;

    // en low for one cycle mid-stall forgets the stall
    valid[1] = 1'b1;
    step("en_stall");
    en = 1'b0;
    step("en_off");
    en = 1'b1; valid[1] = 1'b0;
    step("en_no_drop");
    step("en_idle");

    // Reset mid-stall clears outputs and aborts tracking
    valid = 2'b11; data[15:0] = 16'h1111;
    step("rst_stall");
    valid[1] = 1'b0;
    e_drop = 2'b10; e_cnt = 2'd1; e_fv = 1'b1; e_fch = 1'b1; e_fcode = 2'd1;
    step("rst_pre_drop");
    rst_n = 1'b0; zero_exp();
    step("rst_mid_stall");
    rst_n = 1'b1; data[15:0] = 16'h2222;
    for (int k = 0; k < 3; k++) step("rst_post_stall");
    ready[0] = 1'b1;
    step("rst_post_hs");
    valid[0] = 1'b0; ready[0] = 1'b0;
    step("rst_post_idle");

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
